// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals shared by the
// memory port arbiter and the pipeline/memory that surround it.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          ifReq;
  logic [AW-1:0] ifAddr;
  logic [DW-1:0] ifRdata;
  logic          ifReady;
  logic          dReq;
  logic          dWe;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata;
  logic [DW-1:0] dRdata;
  logic          dReady;
  logic          memEn;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;
  logic          stallIF;
  logic          stallMEM;

  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata,
    input  ifRdata, ifReady, dRdata, dReady,
    input  memEn, memWe, memAddr, memWdata, stallIF, stallMEM
  );

  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata,
    output ifRdata, ifReady, dRdata, dReady,
    output memEn, memWe, memAddr, memWdata, stallIF, stallMEM
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch
// and the memory stage; data requests win, results return as ready pulses.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned      CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] wdata_q, wdata_n;
  logic          we_q, we_n;
  logic [DW-1:0] if_rdata_q, if_rdata_n;
  logic [DW-1:0] d_rdata_q, d_rdata_n;
  logic          if_ready_q, if_ready_n;
  logic          d_ready_q, d_ready_n;
  logic          busy;
  logic          last;

  assign busy = (state != IDLE);
  assign last = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      we_q       <= we_n;
      if_rdata_q <= if_rdata_n;
      d_rdata_q  <= d_rdata_n;
      if_ready_q <= if_ready_n;
      d_ready_q  <= d_ready_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    we_n       = we_q;
    if_rdata_n = if_rdata_q;
    d_rdata_n  = d_rdata_q;
    if_ready_n = 1'b0;
    d_ready_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // A requester whose ready is high this cycle is still showing the
        // request that just completed, so it must not be granted again.
        if (bus.dReq && !d_ready_q) begin
          state_n = BUSY_D;
          cnt_n   = CNT_LAST;
          addr_n  = bus.dAddr;
          we_n    = bus.dWe;
          wdata_n = bus.dWdata;
        end else if (bus.ifReq && !if_ready_q) begin
          state_n = BUSY_I;
          cnt_n   = CNT_LAST;
          addr_n  = bus.ifAddr;
          we_n    = 1'b0;
          wdata_n = '0;
        end
      end
      BUSY_D: begin
        if (last) begin
          state_n = IDLE;
          if (bus.dReq) begin
            d_ready_n = 1'b1;
            if (!we_q) d_rdata_n = bus.memRdata;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      BUSY_I: begin
        // A withdrawn fetch still occupies the port but returns nothing.
        if (last) begin
          state_n = IDLE;
          if (bus.ifReq) begin
            if_ready_n = 1'b1;
            if_rdata_n = bus.memRdata;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.memEn    = busy;
  assign bus.memWe    = busy && we_q && last;
  assign bus.memAddr  = busy ? addr_q : '0;
  assign bus.memWdata = busy ? wdata_q : '0;
  assign bus.ifRdata  = if_rdata_q;
  assign bus.dRdata   = d_rdata_q;
  assign bus.ifReady  = if_ready_q;
  assign bus.dReady   = d_ready_q;
  assign bus.stallIF  = bus.ifReq && !if_ready_q;
  assign bus.stallMEM = bus.dReq && !d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter, checked every cycle
// against a transaction-timed reference model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) intf ();

  mem_port_arbiter #(.LATENCY(LAT), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: owner 0 = idle, 1 = data access, 2 = fetch access.
  // An access granted in cycle g occupies cycles g+1 .. g+LAT.
  longint      cur = 0;
  longint      start = 0;
  int          owner = 0;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic        m_we, m_ir, m_dr, prev_ir, prev_dr, was_rst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cur);
    end
  endtask

  task automatic check_all();
    bit fin;
    fin = (owner != 0) && (cur == start + LAT - 1);
    check_eq("memEn",    32'(intf.memEn),    32'(owner != 0));
    check_eq("memWe",    32'(intf.memWe),    32'(owner == 1 && m_we && fin));
    check_eq("ifReady",  32'(intf.ifReady),  32'(m_ir));
    check_eq("dReady",   32'(intf.dReady),   32'(m_dr));
    check_eq("ifRdata",  intf.ifRdata,       m_ird);
    check_eq("dRdata",   intf.dRdata,        m_drd);
    check_eq("stallIF",  32'(intf.stallIF),  32'(intf.ifReq && !m_ir));
    check_eq("stallMEM", 32'(intf.stallMEM), 32'(intf.dReq && !m_dr));
    if (owner != 0)
      check_eq("memAddr", intf.memAddr, m_addr);
    if (owner == 1)
      check_eq("memWdata", intf.memWdata, m_wdata);
    if (was_rst) begin
      check_eq("memAddr_rst",  intf.memAddr,  32'h0);
      check_eq("memWdata_rst", intf.memWdata, 32'h0);
    end
  endtask

  task automatic model_update();
    logic nir, ndr;
    nir = 1'b0;
    ndr = 1'b0;
    prev_ir = m_ir;
    prev_dr = m_dr;
    was_rst = rst;
    if (rst) begin
      owner = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
      m_ird = '0; m_drd = '0; m_ir = 1'b0; m_dr = 1'b0;
    end else begin
      if (owner != 0) begin
        if (cur == start + LAT - 1) begin
          if (owner == 1 && intf.dReq) begin
            ndr = 1'b1;
            if (!m_we) m_drd = intf.memRdata;
          end
          if (owner == 2 && intf.ifReq) begin
            nir = 1'b1;
            m_ird = intf.memRdata;
          end
          owner = 0;
        end
      end else if (intf.dReq && !m_dr) begin
        owner = 1; start = cur + 1;
        m_addr = intf.dAddr; m_we = intf.dWe; m_wdata = intf.dWdata;
      end else if (intf.ifReq && !m_ir) begin
        owner = 2; start = cur + 1;
        m_addr = intf.ifAddr; m_we = 1'b0; m_wdata = '0;
      end
      m_ir = nir;
      m_dr = ndr;
    end
    cur++;
  endtask

  // Check the current cycle, then advance one clock edge.
  task automatic cycle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_update();
      #1;
    end
  endtask

  // Pipeline-like requesters: a request is held until its ready pulse,
  // occasionally withdrawn, and replaced the cycle after completion.
  task automatic drive_random();
    if (prev_ir || !intf.ifReq) begin
      intf.ifReq  = ($urandom_range(0, 2) != 0);
      intf.ifAddr = $urandom & 32'hFFFF_FFFC;
    end else if ($urandom_range(0, 19) == 0) begin
      intf.ifReq = 1'b0;
    end
    if (prev_dr || !intf.dReq) begin
      intf.dReq   = ($urandom_range(0, 2) == 0);
      intf.dWe    = ($urandom_range(0, 1) == 1);
      intf.dAddr  = $urandom & 32'hFFFF_FFFC;
      intf.dWdata = $urandom;
    end else if ($urandom_range(0, 39) == 0) begin
      intf.dReq = 1'b0;
    end
    rst           = ($urandom_range(0, 63) == 0);
    intf.memRdata = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    intf.ifReq = 1'b1; intf.ifAddr = 32'h40;
    intf.dReq = 1'b0; intf.dWe = 1'b0; intf.dAddr = '0; intf.dWdata = '0;
    intf.memRdata = 32'h0050_0093;
    @(posedge clk);
    model_update();
    #1;
    cycle(1);

    // Single fetch from 0x40.
    rst = 1'b0;
    cycle(4);
    intf.ifReq = 1'b0;
    cycle(1);

    // Simultaneous load 0x100 and fetch 0x44: data wins.
    intf.dReq = 1'b1; intf.dWe = 1'b0; intf.dAddr = 32'h100;
    intf.ifReq = 1'b1; intf.ifAddr = 32'h44; intf.memRdata = 32'h0000_DEAD;
    cycle(4);
    intf.dReq = 1'b0;
    cycle(3);
    intf.ifReq = 1'b0;
    cycle(1);

    // Store 0x1234 to 0x200.
    intf.dReq = 1'b1; intf.dWe = 1'b1; intf.dAddr = 32'h200; intf.dWdata = 32'h1234;
    intf.memRdata = 32'hCAFE_F00D;
    cycle(4);
    intf.dReq = 1'b0;
    cycle(1);

    // Fetch withdrawn after the grant.
    intf.ifReq = 1'b1; intf.ifAddr = 32'h80;
    cycle(1);
    intf.ifReq = 1'b0;
    cycle(3);

    // Reset in the middle of a fetch, then the fetch is served again.
    intf.ifReq = 1'b1; intf.ifAddr = 32'hC0; intf.memRdata = 32'h1111_2222;
    cycle(1);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    cycle(5);
    intf.ifReq = 1'b0;
    cycle(1);

    for (int unsigned k = 0; k < 3000; k++) begin
      drive_random();
      cycle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the five-stage RISC-V pipeline. It latches the winning request, drives the memory port for the configured access latency, returns read data with a one-cycle ready pulse, and produces per-stage stall signals consumed by the hazard unit alongside its load-use stall.

## Interface
- LATENCY, 2, memory cycles per access (≥1)
- AW, 32, address width
- DW, 32, data width

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active high
- ifReq  input  1  fetch request; held stable by fetch stage while stalled
- ifAddr  input  AW  fetch address
- ifRdata  output  DW  fetched instruction, valid when ifReady=1
- ifReady  output  1  one-cycle pulse: fetch access complete
- dReq  input  1  data request from memory stage; held stable while stalled
- dWe  input  1  1=store, 0=load
- dAddr  input  AW  data address
- dWdata  input  DW  store data
- dRdata  output  DW  load data, valid when dReady=1
- dReady  output  1  one-cycle pulse: data access complete
- memEn  output  1  memory access active
- memWe  output  1  memory write strobe
- memAddr  output  AW  memory address
- memWdata  output  DW  memory write data
- memRdata  input  DW  memory read data, valid on final access cycle
- stallIF  output  1  ifReq & ~ifReady
- stallMEM  output  1  dReq & ~dReady

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I. Latency counter cnt, width clog2(LATENCY) (min 1).
- IDLE: grant dReq first (older instruction), else ifReq. On grant: latch addr/we/wdata into owner registers, cnt←LATENCY-1, go BUSY_D/BUSY_I. No request: stay IDLE.
- Completion-cycle exclusion: in the cycle ifReady=1, ifReq is not eligible for grant (it refers to the completed access); same for dReq when dReady=1. The other requester may be granted that cycle.
- BUSY_x: memEn=1, memAddr=latched address, memWdata=latched wdata. memWe=1 only when latched we=1 and cnt==0 (single write per store). cnt decrements each cycle.
- BUSY_x with cnt==0: capture memRdata into ifRdata/dRdata register (loads/fetches only; stores leave dRdata unchanged), set corresponding ready for next cycle, go IDLE.
- Abort: if ifReq deasserts while BUSY_I (branch flush), access runs to completion (memory cannot cancel) but ifReady is suppressed and ifRdata not updated. dReq is never withdrawn mid-access; if it is, behaviour matches fetch abort.
- ifRdata/dRdata hold last captured values between pulses.
- Stalls are combinational from req inputs and registered ready.

## Timing
- Reset (rst=1 at edge): state=IDLE, cnt=0, ifReady=dReady=0, ifRdata=dRdata=0, latched addr/wdata/we=0. Outputs after reset: memEn=memWe=0, memAddr=memWdata=0; stallIF/stallMEM follow inputs.
- rst mid-access: access abandoned immediately, no ready pulse, memEn drops next cycle.
- Request in cycle t (IDLE) → memEn cycles t+1..t+LATENCY → ready pulse cycle t+LATENCY+1. Stall asserted cycles t..t+LATENCY.
- Back-to-back: the ready cycle is IDLE and may grant the other requester; port throughput one access per LATENCY+1 cycles.
- Simultaneous dReq and ifReq in IDLE: data served first; fetch granted in data's ready cycle; fetch ready at t+2·(LATENCY+1).
- LATENCY=1: cnt is constant 0; each BUSY state lasts one cycle.

## Test plan
- Reset: drive rst=1 two cycles with ifReq=1 → ifReady=dReady=0, memEn=0, ifRdata=0; stallIF=1.
- LATENCY=2, ifReq=1 ifAddr=0x40 at t=0, memRdata=0x00500093 → memEn=1 memAddr=0x40 at t=1,2; ifReady=1 ifRdata=0x00500093 at t=3 only; stallIF=1 t=0..2.
- Simultaneous dReq (load 0x100, memRdata=0xDEAD) and ifReq (0x44) at t=0 → dReady at t=3 dRdata=0xDEAD; fetch memAddr=0x44 t=4,5; ifReady t=6.
- Store dWe=1 dAddr=0x200 dWdata=0x1234 → memWe=1 exactly one cycle (t=2) with memAddr=0x200 memWdata=0x1234; dReady t=3; dRdata unchanged.
- Fetch abort: ifReq dropped at t=1 → memEn still high t=1,2; no ifReady at t=3; ifRdata unchanged.
- rst asserted at t=1 mid-fetch → memEn=0 from t=2, no ifReady, state IDLE; new ifReq served normally afterwards.
